// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with branch/jump/call/return redirects and exception entry/exit
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(32'h0000_0080),
  parameter int              JIDX_W       = 28,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_ready,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [15:0]       br_off,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jidx,
  input  logic              jreg,
  input  logic              call,
  input  logic              ret,
  input  logic [XLEN-1:0]   rs_val,
  input  logic              exc,
  input  logic              eret,
  output logic [XLEN-1:0]   pc,
  output logic              fetch_valid,
  output logic [XLEN-1:0]   epc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_udf
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {BOOT, RUN, EXC} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_nxt, epc_nxt;
  logic [XLEN-1:0] pc4, br_tgt, jump_tgt, rs_aligned, ras_top;
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   wr_ptr, top_ptr;
  logic [CW-1:0]   ras_cnt;
  logic            advance, push, pop, ovf_nxt, udf_nxt;

  assign advance    = (state == RUN) && fetch_ready && !stall;
  assign pc4        = pc + XLEN'(4);
  assign br_tgt     = pc4 + {{(XLEN-18){br_off[15]}}, br_off, 2'b00};
  assign jump_tgt   = {pc4[XLEN-1:JIDX_W+2], jidx, 2'b00};
  assign rs_aligned = rs_val & ALIGN_MASK;
  assign top_ptr    = wr_ptr - PW'(1);
  assign ras_top    = ras_mem[top_ptr];
  assign ras_empty  = (ras_cnt == '0);
  assign ras_full   = (ras_cnt == CW'(RAS_DEPTH));

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    epc_nxt     = epc;
    push        = 1'b0;
    pop         = 1'b0;
    ovf_nxt     = ras_ovf;
    udf_nxt     = ras_udf;
    fetch_valid = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      EXC:  state_nxt = RUN;
      RUN: begin
        fetch_valid = 1'b1;
        // exc and eret act in RUN regardless of stall/fetch_ready
        if (exc) begin
          epc_nxt   = pc;
          pc_nxt    = EXC_VECTOR;
          state_nxt = EXC;
        end else if (eret) begin
          pc_nxt = epc;
        end else if (advance) begin
          if (ret) begin
            if (ras_empty) begin
              pc_nxt  = rs_aligned;
              udf_nxt = 1'b1;
            end else begin
              pc_nxt = ras_top;
              pop    = 1'b1;
            end
          end else if (jreg) begin
            pc_nxt = rs_aligned;
            push   = call;
          end else if (jump) begin
            pc_nxt = jump_tgt;
            push   = call;
          end else if (br_taken) begin
            pc_nxt = br_tgt;
          end else begin
            pc_nxt = pc4;
          end
        end
      end
      default: state_nxt = BOOT;
    endcase
    if (push && ras_full) ovf_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= BOOT;
      pc      <= RESET_VECTOR & ALIGN_MASK;
      epc     <= '0;
      wr_ptr  <= '0;
      ras_cnt <= '0;
      ras_ovf <= 1'b0;
      ras_udf <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt & ALIGN_MASK;
      epc     <= epc_nxt;
      ras_ovf <= ovf_nxt;
      ras_udf <= udf_nxt;
      // A push while full lands on the oldest slot, so depth saturates
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (!ras_full) ras_cnt <= ras_cnt + CW'(1);
      end else if (pop) begin
        wr_ptr  <= top_ptr;
        ras_cnt <= ras_cnt - CW'(1);
      end
    end
  end

  // Entries are only readable while counted, so the array needs no reset
  always_ff @(posedge clk) begin
    if (push) ras_mem[wr_ptr] <= pc4;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
  logic        clk, rst, fetch_ready, stall, br_taken, jump, jreg, call, ret, exc, eret;
  logic [15:0] br_off;
  logic [27:0] jidx;
  logic [31:0] rs_val, pc, epc;
  logic        fetch_valid, ras_empty, ras_full, ras_ovf, ras_udf;
  int          n_checks = 0;
  int          n_fail = 0;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .stall(stall),
    .br_taken(br_taken), .br_off(br_off), .jump(jump), .jidx(jidx),
    .jreg(jreg), .call(call), .ret(ret), .rs_val(rs_val), .exc(exc),
    .eret(eret), .pc(pc), .fetch_valid(fetch_valid), .epc(epc),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_udf(ras_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; br_taken = 0; br_off = '0; jump = 0; jidx = '0;
    jreg = 0; call = 0; ret = 0; rs_val = '0; exc = 0; eret = 0;
  endtask

  task automatic jreg_to(input logic [31:0] a);
    jreg = 1; rs_val = a;
    tick();
    jreg = 0; rs_val = '0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    rst = 0;
    #2;
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b expected 0", fetch_valid); end
    n_checks++; if (ras_empty !== 1'b1 || ras_ovf !== 1'b0 || ras_udf !== 1'b0) begin n_fail++; $display("FAIL reset_ras: got e%b o%b u%b expected e1 o0 u0", ras_empty, ras_ovf, ras_udf); end
    tick();
    rst = 1;
    #1;
    n_checks++; if (fetch_valid !== 1'b0 || pc !== 32'h0) begin n_fail++; $display("FAIL boot: got fv%b pc %h expected fv0 pc 0", fetch_valid, pc); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (pc !== exp_pc[i] || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq_%0d: got pc %h fv%b expected pc %h fv1", i, pc, fetch_valid, exp_pc[i]); end
    end
  endtask

  task automatic test_hold();
    fetch_ready = 0;
    tick();
    n_checks++; if (pc !== 32'hC) begin n_fail++; $display("FAIL hold_fetch_ready: got %h expected %h", pc, 32'hC); end
    fetch_ready = 1; stall = 1;
    tick();
    n_checks++; if (pc !== 32'hC) begin n_fail++; $display("FAIL hold_stall: got %h expected %h", pc, 32'hC); end
    stall = 0;
  endtask

  task automatic test_branch();
    jreg_to(32'h100);
    n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL jreg: got %h expected %h", pc, 32'h100); end
    br_taken = 1; br_off = 16'hFFFE; stall = 1;
    tick();
    n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL branch_stalled: got %h expected %h", pc, 32'h100); end
    stall = 0;
    tick();
    n_checks++; if (pc !== 32'h0FC) begin n_fail++; $display("FAIL branch_back: got %h expected %h", pc, 32'h0FC); end
    clear_inputs();
  endtask

  task automatic test_jump_call();
    jreg_to(32'h1000);
    jump = 1; call = 1; jidx = 28'h40;
    tick();
    n_checks++; if (pc !== 32'h100 || ras_empty !== 1'b0) begin n_fail++; $display("FAIL jump_call: got pc %h empty %b expected pc 100 empty 0", pc, ras_empty); end
    clear_inputs();
    ret = 1;
    tick();
    n_checks++; if (pc !== 32'h1004 || ras_empty !== 1'b1) begin n_fail++; $display("FAIL ret: got pc %h empty %b expected pc 1004 empty 1", pc, ras_empty); end
    clear_inputs();
    call = 1;
    tick();
    n_checks++; if (pc !== 32'h1008 || ras_empty !== 1'b1) begin n_fail++; $display("FAIL bare_call: got pc %h empty %b expected pc 1008 empty 1", pc, ras_empty); end
    clear_inputs();
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_ret [4] = '{32'h3404, 32'h3304, 32'h3204, 32'h3104};
    for (int i = 1; i <= 5; i++) begin
      jreg = 1; call = 1; rs_val = 32'h3000 + 32'h100 * i;
      tick();
      if (i == 4) begin
        n_checks++; if (ras_full !== 1'b1 || ras_ovf !== 1'b0) begin n_fail++; $display("FAIL ras_4calls: got full %b ovf %b expected full 1 ovf 0", ras_full, ras_ovf); end
      end
    end
    n_checks++; if (ras_full !== 1'b1 || ras_ovf !== 1'b1 || pc !== 32'h3500) begin n_fail++; $display("FAIL ras_5calls: got full %b ovf %b pc %h expected full 1 ovf 1 pc 3500", ras_full, ras_ovf, pc); end
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      ret = 1; rs_val = 32'h9990;
      tick();
      n_checks++; if (pc !== exp_ret[i]) begin n_fail++; $display("FAIL ras_ret_%0d: got %h expected %h", i, pc, exp_ret[i]); end
    end
    n_checks++; if (ras_empty !== 1'b1 || ras_udf !== 1'b0) begin n_fail++; $display("FAIL ras_drained: got empty %b udf %b expected empty 1 udf 0", ras_empty, ras_udf); end
    rs_val = 32'h5003;
    tick();
    n_checks++; if (pc !== 32'h5000 || ras_udf !== 1'b1) begin n_fail++; $display("FAIL ras_underflow: got pc %h udf %b expected pc 5000 udf 1", pc, ras_udf); end
    clear_inputs();
    jreg = 1; call = 1; rs_val = 32'h7000;
    tick();
    ret = 1; rs_val = 32'h8000;
    tick();
    n_checks++; if (pc !== 32'h5004 || ras_empty !== 1'b1) begin n_fail++; $display("FAIL ret_beats_call: got pc %h empty %b expected pc 5004 empty 1", pc, ras_empty); end
    clear_inputs();
  endtask

  task automatic test_exception();
    jreg_to(32'h200);
    exc = 1; stall = 1; br_taken = 1; br_off = 16'h0004;
    tick();
    n_checks++; if (epc !== 32'h200 || pc !== 32'h80 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL exc_entry: got epc %h pc %h fv %b expected epc 200 pc 80 fv 0", epc, pc, fetch_valid); end
    clear_inputs();
    tick();
    n_checks++; if (pc !== 32'h80 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL exc_resume: got pc %h fv %b expected pc 80 fv 1", pc, fetch_valid); end
    eret = 1;
    tick();
    n_checks++; if (pc !== 32'h200 || epc !== 32'h200) begin n_fail++; $display("FAIL eret: got pc %h epc %h expected pc 200 epc 200", pc, epc); end
    clear_inputs();
    n_checks++; if (ras_ovf !== 1'b1 || ras_udf !== 1'b1) begin n_fail++; $display("FAIL sticky: got ovf %b udf %b expected 1 1", ras_ovf, ras_udf); end
  endtask

  task automatic test_wrap();
    jreg_to(32'hFFFF_FFFC);
    tick();
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL pc_wrap: got %h expected %h", pc, 32'h0); end
    jreg_to(32'hC000_0000);
    jump = 1; jidx = 28'h1;
    tick();
    n_checks++; if (pc !== 32'hC000_0004) begin n_fail++; $display("FAIL jump_region: got %h expected %h", pc, 32'hC000_0004); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_exc();
    jreg_to(32'h400);
    exc = 1;
    tick();
    exc = 0;
    rst = 0;
    #1;
    n_checks++; if (pc !== 32'h0 || epc !== 32'h0 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_exc: got pc %h epc %h fv %b expected 0 0 0", pc, epc, fetch_valid); end
    n_checks++; if (ras_ovf !== 1'b0 || ras_udf !== 1'b0 || ras_empty !== 1'b1) begin n_fail++; $display("FAIL rst_flags: got ovf %b udf %b empty %b expected 0 0 1", ras_ovf, ras_udf, ras_empty); end
    @(negedge clk);
    rst = 1;
    tick();
    n_checks++; if (pc !== 32'h0 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL rst_rerun: got pc %h fv %b expected 0 1", pc, fetch_valid); end
  endtask

  initial begin
    rst = 0; fetch_ready = 1;
    clear_inputs();
    test_reset();
    test_hold();
    test_branch();
    test_jump_call();
    test_ras_overflow();
    test_exception();
    test_wrap();
    test_reset_mid_exc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
